// File: rtl/cic_comp_pkg.sv
// Shared constants, state encoding and coefficient table for the CIC droop-compensation FIR.
package cic_comp_pkg;

  localparam int TAPS   = 15;
  localparam int SHIFT  = 7;
  localparam int ACC_W  = 20;
  localparam int DATA_W = 8;
  localparam int PTR_W  = $clog2(TAPS);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    MAC,
    OUT
  } state_t;

  // Q1.7, symmetric, sums to 128 for unity DC gain.
  localparam logic signed [DATA_W-1:0] COEF [TAPS] = '{
    -8'sd1, 8'sd1, 8'sd2, -8'sd3, -8'sd6, 8'sd8, 8'sd26, 8'sd74,
    8'sd26, 8'sd8, -8'sd6, -8'sd3, 8'sd2, 8'sd1, -8'sd1
  };

endpackage

// File: rtl/cic_comp_fir_round_sat.sv
// Combinational round-half-up and clamp from an ACC_W-bit accumulator to a signed 8-bit sample.
module round_sat #(
  parameter int ACC_W = 20,
  parameter int SHIFT = 7
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [7:0]       y
);

  localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(1) <<< (SHIFT - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0] SAT_MIN = -(ACC_W+1)'(128);

  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shifted;

  // NOTE: combinational blocks use blocking '=' and assign every output on every path, so no latch is inferred.
  always_comb begin
    sum     = (ACC_W+1)'(acc) + HALF;
    shifted = sum >>> SHIFT;
    if (shifted > SAT_MAX)      y = 8'sh7f;
    else if (shifted < SAT_MIN) y = 8'sh80;
    else                        y = shifted[7:0];
  end

endmodule

// File: rtl/cic_comp_fir.sv
// 15-tap CIC droop-compensation FIR: d_clk edge detect, one-deep pending register,
// circular delay line and a single time-multiplexed MAC on the system clock.
module cic_comp_fir
  import cic_comp_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] d_in,
  input  logic                     d_clk,
  output logic signed [DATA_W-1:0] d_out,
  output logic                     d_valid,
  output logic                     busy,
  output logic                     overrun
);

  state_t                    state, state_nxt;
  logic                      d_clk_q;
  logic                      rise;
  logic                      pend_flag;
  logic signed [DATA_W-1:0]  pend_data;
  logic signed [DATA_W-1:0]  dly_line [TAPS];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [PTR_W-1:0]          k;
  logic signed [ACC_W-1:0]   acc;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W-1:0]  y;

  assign rise = d_clk & ~d_clk_q;
  assign busy = (state != IDLE);
  assign prod = COEF[k] * dly_line[rd_ptr];

  round_sat #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_round_sat (
    .acc (acc),
    .y   (y)
  );

  // A rise seen while idle or finishing goes straight to WRITE so latency stays fixed.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pend_flag || rise) state_nxt = WRITE;
      WRITE:   state_nxt = MAC;
      MAC:     if (k == PTR_W'(TAPS - 1)) state_nxt = OUT;
      OUT:     state_nxt = (pend_flag || rise) ? WRITE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      d_clk_q   <= 1'b0;
      pend_flag <= 1'b0;
      pend_data <= '0;
      overrun   <= 1'b0;
    end else begin
      state   <= state_nxt;
      d_clk_q <= d_clk;
      if (rise) begin
        // WRITE frees the slot this same cycle, so a coincident sample is still accepted.
        if (!pend_flag || state == WRITE) begin
          pend_data <= d_in;
          pend_flag <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (state == WRITE) begin
        pend_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the delay line is reset explicitly so an aborted run leaves no stale history.
      for (int i = 0; i < TAPS; i++) dly_line[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      k       <= '0;
      acc     <= '0;
      d_out   <= '0;
      d_valid <= 1'b0;
    end else begin
      d_valid <= 1'b0;
      unique case (state)
        WRITE: begin
          dly_line[wr_ptr] <= pend_data;
          rd_ptr <= wr_ptr;
          wr_ptr <= (wr_ptr == PTR_W'(TAPS - 1)) ? '0 : wr_ptr + 1'b1;
          acc    <= '0;
          k      <= '0;
        end
        MAC: begin
          acc    <= acc + ACC_W'(prod);
          k      <= k + 1'b1;
          rd_ptr <= (rd_ptr == '0) ? PTR_W'(TAPS - 1) : rd_ptr - 1'b1;
        end
        OUT: begin
          d_out   <= y;
          d_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cic_comp_fir.md
# cic_comp_fir

CIC droop-compensation FIR that sits directly downstream of the CIC decimator in the AM demodulator chain. It detects each rising edge of the CIC's output-rate strobe `d_clk`, stores the 8-bit decimated sample in a circular delay line, and computes a 15-tap fixed-coefficient convolution with one time-multiplexed multiply-accumulate per clock. It then emits a rounded, saturated 8-bit sample with a one-cycle valid pulse. All logic runs on the fast system clock; `d_clk` is treated as data, not as a clock.

## Interface
- `TAPS`, 15: number of taps; must match the coefficient table.
- `SHIFT`, 7: right shift applied to the accumulator. Coefficients are Q1.7 and sum to 128, giving unity DC gain.
- `ACC_W`, 20: accumulator width; must be at least 8 + 8 + ceil(log2 TAPS).
- `clk`  in  1: system clock, the same clock that drives the CIC. Single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `d_in`  in  8 signed: decimated sample from the CIC, valid in the cycle the `d_clk` rise is detected.
- `d_clk`  in  1: CIC output strobe. Each rising edge marks one new sample.
- `d_out`  out  8 signed: filtered sample. Registered; holds its value between updates.
- `d_valid`  out  1: one-cycle pulse when `d_out` updates.
- `busy`  out  1: high in every state other than IDLE.
- `overrun`  out  1: sticky; set when a sample is dropped.

## Operation
- Edge detect:
  - `d_clk_q` is a registered copy of `d_clk`; `rise = d_clk & ~d_clk_q`.
  - On `rise`, `d_in` is captured into `pend_data` and `pend_flag` is set.
- Delay line:
  - `buf[0..TAPS-1]`, 8-bit signed, with write pointer `wr_ptr` (next slot to write).
  - WRITE stores `pend_data` at `wr_ptr`, then `wr_ptr` wraps from `TAPS-1` to 0.
  - The newest sample is at `wr_ptr-1` mod `TAPS`.
  - MAC tap `k` multiplies `COEF[k]` by `buf[(newest - k) mod TAPS]`.
- FSM states and transitions:
  - IDLE: go to WRITE if `pend_flag`.
  - WRITE: write the buffer, clear `pend_flag`, clear the accumulator, set `k = 0`, go to MAC.
  - MAC: `acc += COEF[k]*sample` (signed, sign-extended to `ACC_W`), `k++`. Go to OUT after `k = TAPS-1`.
  - OUT: load `d_out`, pulse `d_valid`. Go to WRITE if `pend_flag`, else IDLE.
- Rounding and saturation:
  - `y = (acc + 2^(SHIFT-1)) >>> SHIFT`, arithmetic shift, so ties round toward +inf.
  - `y` is clamped to [-128, 127].
- Pending and overrun:
  - The pending register is one deep.
  - A `rise` in the same cycle WRITE clears `pend_flag` is accepted: the new sample is captured and the flag stays set.
  - A `rise` while `pend_flag` is set and not being cleared that cycle drops the new sample (the old pending sample is kept) and sets `overrun`. `overrun` stays set until `rst`.
- Reset values:
  - `d_out = 0`, `d_valid = 0`, `busy = 0`, `overrun = 0`.
  - FSM in IDLE; `pend_flag = 0`, `d_clk_q = 0`, `wr_ptr = 0`; every buf entry = 0; `acc = 0`.
  - Reset asserted mid-computation aborts the computation: no `d_valid` is emitted for the in-flight sample.

## Timing
- Cycle `t` = the cycle in which `rise` is high.
- WRITE at `t+1`; MAC at `t+2` through `t+1+TAPS`; OUT at `t+2+TAPS`.
- `d_valid` is high in cycle `t+3+TAPS` (t+18 with defaults). Latency is `TAPS+3` cycles.
- Throughput is one sample per `TAPS+2` cycles (17 with defaults). The CIC `decimation_ratio` must be at least 17 for loss-free operation.
- A back-to-back pending sample enters WRITE in the cycle after OUT. Its `d_valid` follows the previous one by exactly `TAPS+2` cycles.
- `d_clk` held high produces no further samples; a new sample requires a fall and then a rise.

## Structure
- Shared package/include `cic_comp_pkg` holds:
  - `TAPS`, `SHIFT`, `ACC_W`;
  - the FSM state encoding (IDLE, WRITE, MAC, OUT);
  - the coefficient constant `COEF[0..14]` = -1, 1, 2, -3, -6, 8, 26, 74, 26, 8, -6, -3, 2, 1, -1. The table is symmetric, sums to 128, and has absolute sum 168.
- One sub-module, `round_sat`: combinational round-and-clamp from `ACC_W` bits to 8 bits, parameterized by `SHIFT`. It is reusable by later stages.
- The top level `cic_comp_fir` contains the edge detect, the pending register, the delay line, the FSM and the MAC. Target size is about 200 lines.

## Test plan
- Reset: drive `rst` for 3 cycles with `d_clk` toggling. All outputs must be 0, with no `d_valid` during reset or in the cycle after release.
- Impulse: one edge with `d_in = 64`, then edges with 0, spaced 20 cycles apart. The successive `d_out` values must be 0, 1, 1, -1, -3, 4, 13, 37, 13, 4, -3, -1, 1, 1, 0, then 0. Each `d_valid` must come exactly 18 cycles after its rise.
- DC: 20 edges with `d_in = 100`. `d_out` must ramp, then hold at 100 from the 15th output onward.
- Saturation: feed 15 samples with values +127 where COEF > 0 and -128 where COEF < 0. The accumulator reaches 21356 and `d_out` must equal 127, not 167.
- Overrun and pending:
  - Edges at `t`, `t+5`, `t+8`, carrying samples A, B, C.
  - A must give `d_valid` at `t+18`; B must give `d_valid` at `t+35`.
  - C must be dropped, with `overrun` rising at `t+9` and staying set.
  - An edge coinciding with a WRITE cycle must be accepted without `overrun`.
- Reset mid-operation: assert `rst` at `t+10` during MAC. There must be no `d_valid` and the buffer must be cleared. An impulse after release must reproduce the impulse-test sequence exactly.
